// File: rtl/tt_prog_loader.sv
// tt_prog_loader: write side of the tinycore instruction memory.
// Receives a framed program (SYNC, LEN, LEN payload bytes, CHK) over a
// byte-wide valid/ready stream, writes the payload into a DEPTH x 8
// instruction memory and holds the core stopped until a frame has loaded
// with a good checksum (CHK = LEN + sum of payload, mod 256).
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_in_data        stream byte
//   i_in_valid       i_in_data valid
//   o_in_ready       loader accepts (transfer on valid && ready)
//   o_mem_we         instruction memory write strobe, one cycle per byte
//   o_mem_addr       write address
//   o_mem_wdata      write data
//   o_core_run       1 = core may execute
//   o_load_done      last frame loaded OK (level)
//   o_load_err       last frame failed (level)
//   o_err_code       00 none, 01 bad LEN, 10 checksum, 11 timeout
//   o_words_loaded   LEN of the last good frame
module tt_prog_loader #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_core_run,
   output logic              o_load_done,
   output logic              o_load_err,
   output logic [1:0]        o_err_code,
   output logic [ADDR_W:0]   o_words_loaded
);

   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam int unsigned TMO_W = 16;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CHK  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t             r_state,  w_state;
   logic [LEN_W-1:0]   r_len,    w_len;
   logic [ADDR_W-1:0]  r_idx,    w_idx;
   logic [7:0]         r_sum,    w_sum;
   logic [TMO_W-1:0]   r_tmo,    w_tmo;
   logic               r_ready;
   logic               r_mem_we,       w_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr,     w_mem_addr;
   logic [7:0]         r_mem_wdata,    w_mem_wdata;
   logic               r_core_run,     w_core_run;
   logic               r_load_done,    w_load_done;
   logic               r_load_err,     w_load_err;
   logic [1:0]         r_err_code,     w_err_code;
   logic [LEN_W-1:0]   r_words_loaded, w_words_loaded;

   logic w_xfer;
   logic w_is_sync;
   logic w_len_bad;
   logic w_last_byte;
   logic w_in_frame;
   logic w_tmo_hit;

   assign w_xfer      = i_in_valid && r_ready;
   assign w_is_sync   = (i_in_data == SYNC);
   assign w_len_bad   = (i_in_data == 8'd0) || (32'(i_in_data) > DEPTH);
   assign w_last_byte = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
   assign w_in_frame  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
   // Idle cycle that brings the in-frame idle count up to TIMEOUT.
   assign w_tmo_hit   = (TIMEOUT != 0) && w_in_frame && !w_xfer &&
                        (r_tmo == TMO_W'(TIMEOUT - 1));

   // Next-state and next-output logic.
   always_comb begin
      w_state        = r_state;
      w_len          = r_len;
      w_idx          = r_idx;
      w_sum          = r_sum;
      w_tmo          = r_tmo;
      w_mem_we       = 1'b0;
      w_mem_addr     = r_mem_addr;
      w_mem_wdata    = r_mem_wdata;
      w_core_run     = r_core_run;
      w_load_done    = r_load_done;
      w_load_err     = r_load_err;
      w_err_code     = r_err_code;
      w_words_loaded = r_words_loaded;

      if (w_in_frame) begin
         w_tmo = w_xfer ? '0 : (r_tmo + TMO_W'(1));
      end

      if (w_tmo_hit) begin
         w_state    = S_ERR;
         w_load_err = 1'b1;
         w_core_run = 1'b0;
         w_err_code = ERR_TMO;
      end else begin
         case (r_state)
            S_HUNT: begin
               if (w_xfer && w_is_sync) begin
                  w_state = S_LEN;
                  w_tmo   = '0;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  if (w_len_bad) begin
                     w_state    = S_ERR;
                     w_load_err = 1'b1;
                     w_core_run = 1'b0;
                     w_err_code = ERR_LEN;
                  end else begin
                     w_state = S_DATA;
                     w_len   = LEN_W'(i_in_data);
                     w_idx   = '0;
                     w_sum   = i_in_data;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  w_mem_we    = 1'b1;
                  w_mem_addr  = r_idx;
                  w_mem_wdata = i_in_data;
                  w_sum       = r_sum + i_in_data;
                  if (w_last_byte) begin
                     w_state = S_CHK;
                  end else begin
                     w_idx = r_idx + ADDR_W'(1);
                  end
               end
            end
            S_CHK: begin
               if (w_xfer) begin
                  if (i_in_data == r_sum) begin
                     w_state        = S_DONE;
                     w_load_done    = 1'b1;
                     w_core_run     = 1'b1;
                     w_words_loaded = r_len;
                  end else begin
                     w_state    = S_ERR;
                     w_load_err = 1'b1;
                     w_core_run = 1'b0;
                     w_err_code = ERR_CHK;
                  end
               end
            end
            S_DONE, S_ERR: begin
               // A new frame drops the core and clears the previous status.
               if (w_xfer && w_is_sync) begin
                  w_state     = S_LEN;
                  w_tmo       = '0;
                  w_load_done = 1'b0;
                  w_load_err  = 1'b0;
                  w_err_code  = ERR_NONE;
                  w_core_run  = 1'b0;
               end
            end
            default: begin
               w_state = S_HUNT;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_HUNT;
         r_len          <= '0;
         r_idx          <= '0;
         r_sum          <= '0;
         r_tmo          <= '0;
         r_ready        <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_core_run     <= 1'b0;
         r_load_done    <= 1'b0;
         r_load_err     <= 1'b0;
         r_err_code     <= ERR_NONE;
         r_words_loaded <= '0;
      end else begin
         r_state        <= w_state;
         r_len          <= w_len;
         r_idx          <= w_idx;
         r_sum          <= w_sum;
         r_tmo          <= w_tmo;
         r_ready        <= 1'b1;
         r_mem_we       <= w_mem_we;
         r_mem_addr     <= w_mem_addr;
         r_mem_wdata    <= w_mem_wdata;
         r_core_run     <= w_core_run;
         r_load_done    <= w_load_done;
         r_load_err     <= w_load_err;
         r_err_code     <= w_err_code;
         r_words_loaded <= w_words_loaded;
      end
   end

   assign o_in_ready     = r_ready;
   assign o_mem_we       = r_mem_we;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_core_run     = r_core_run;
   assign o_load_done    = r_load_done;
   assign o_load_err     = r_load_err;
   assign o_err_code     = r_err_code;
   assign o_words_loaded = r_words_loaded;

endmodule
